snr_window_estimator: RTL and testbench



---
 rtl/snr_pkg.sv | 20 ++
 rtl/snr_seq_div.sv | 58 +++++
 rtl/snr_window_estimator.sv | 133 +++++++++++++
 tb/tb_snr_window_estimator.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snr_pkg.sv
// Shared types and width helpers for the windowed SNR estimator.
package snr_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDiv  = 2'd1,
    StDone = 2'd2
  } snr_state_e;

  localparam int unsigned SNR_EMA_SHIFT = 2;

  function automatic int unsigned acc_width(int unsigned data_w, int unsigned win_log2);
    return data_w + win_log2;
  endfunction

  function automatic int unsigned q_width(int unsigned acc_w, int unsigned frac_w);
    return acc_w + frac_w;
  endfunction

endpackage

// File: rtl/snr_seq_div.sv
// Generic unsigned restoring divider, one quotient bit per cycle, DVD_W cycles per divide.
module snr_seq_div #(
  parameter int unsigned DVD_W = 22,
  parameter int unsigned DVS_W = 18
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             done_o,
  output logic [DVD_W-1:0] quotient_o
);

  localparam int unsigned CNT_W = $clog2(DVD_W + 1);

  logic [DVD_W-1:0] dq_q;
  logic [DVS_W-1:0] rem_q;
  logic [DVS_W-1:0] dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic [DVS_W:0]   shifted;
  logic [DVS_W:0]   diff;
  logic             ge;

  // Remainder stays below the divisor, so the trial difference's top bit is the borrow.
  always_comb begin
    shifted = {rem_q, dq_q[DVD_W-1]};
    diff    = shifted - {1'b0, dvs_q};
    ge      = ~diff[DVS_W];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      dq_q  <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      dq_q  <= dividend_i;
      rem_q <= '0;
      dvs_q <= divisor_i;
      cnt_q <= CNT_W'(DVD_W);
      run_q <= 1'b1;
    end else if (run_q) begin
      dq_q  <= {dq_q[DVD_W-2:0], ge};
      rem_q <= ge ? diff[DVS_W-1:0] : shifted[DVS_W-1:0];
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) run_q <= 1'b0;
    end
  end

  // High in the cycle whose closing edge retires the final quotient bit.
  assign done_o     = run_q && (cnt_q == CNT_W'(1));
  assign quotient_o = dq_q;

endmodule

// File: rtl/snr_window_estimator.sv
// Windowed SNR estimator: signal/(total-signal) per 2^WIN_LOG2 accepted samples.
// Optional exponential averaging of results when SNR_EMA_EN is defined.
module snr_window_estimator
  import snr_pkg::*;
#(
  parameter int unsigned DATA_W   = 10,
  parameter int unsigned WIN_LOG2 = 8,
  parameter int unsigned FRAC_W   = 4,
  parameter int unsigned OUT_W    = 17
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [DATA_W-1:0] filtered,
  input  logic [DATA_W-1:0] un_filtered,
  output logic [OUT_W-1:0]  snr,
  output logic              snr_valid,
  output logic              zero_noise,
  output logic              busy
);

  localparam int unsigned ACC_W = acc_width(DATA_W, WIN_LOG2);
  localparam int unsigned Q     = q_width(ACC_W, FRAC_W);
  localparam int unsigned CMP_W = (Q > OUT_W) ? Q : OUT_W;

  if ((1 << WIN_LOG2) < Q + 2) begin : gen_win_check
    $error("window too short for the divider to finish");
  end

  snr_state_e state_q, state_d;

  logic [ACC_W-1:0]    fsum_q, usum_q;
  logic [WIN_LOG2-1:0] cnt_q;
  logic [ACC_W-1:0]    sig_full, tot_full;
  logic signed [ACC_W:0] noise;
  logic                noise_pos;
  logic                win_close;
  logic                div_start, div_done;
  logic [Q-1:0]        div_quot;
  logic [CMP_W-1:0]    quot_ext;
  logic [OUT_W-1:0]    raw;
  logic [OUT_W-1:0]    snr_new;
  logic [OUT_W-1:0]    snr_q;
  logic                zn_pend_q, zn_q;

  always_comb begin
    win_close = en && (cnt_q == '1);
    sig_full  = fsum_q + ACC_W'(filtered);
    tot_full  = usum_q + ACC_W'(un_filtered);
    noise     = $signed({1'b0, tot_full}) - $signed({1'b0, sig_full});
    noise_pos = ~noise[ACC_W] && (noise != '0);
    div_start = win_close && noise_pos;
  end

  snr_seq_div #(
    .DVD_W (Q),
    .DVS_W (ACC_W)
  ) u_div (
    .clk        (clk),
    .rstn       (rstn),
    .start_i    (div_start),
    .dividend_i ({sig_full, {FRAC_W{1'b0}}}),
    .divisor_i  (noise[ACC_W-1:0]),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

  always_comb begin
    quot_ext = CMP_W'(div_quot);
    if (zn_pend_q || (quot_ext > CMP_W'({OUT_W{1'b1}}))) raw = '1;
    else                                                  raw = quot_ext[OUT_W-1:0];
  end

`ifdef SNR_EMA_EN
  logic                  ema_first_q;
  logic signed [OUT_W:0] ema_diff, ema_step;

  always_comb begin
    ema_diff = $signed({1'b0, raw}) - $signed({1'b0, snr_q});
    ema_step = ema_diff >>> SNR_EMA_SHIFT;
    snr_new  = ema_first_q ? raw : OUT_W'($signed({1'b0, snr_q}) + ema_step);
  end

  always_ff @(posedge clk) begin
    if (!rstn)                   ema_first_q <= 1'b1;
    else if (state_q == StDone)  ema_first_q <= 1'b0;
  end
`else
  assign snr_new = raw;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (win_close) state_d = noise_pos ? StDiv : StDone;
      StDiv:   if (div_done)  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Accumulation runs in every state; the closing sample resets the sums and wraps the counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      fsum_q    <= '0;
      usum_q    <= '0;
      cnt_q     <= '0;
      zn_pend_q <= 1'b0;
      zn_q      <= 1'b0;
      snr_q     <= '0;
    end else begin
      state_q <= state_d;
      if (en) begin
        cnt_q  <= cnt_q + 1'b1;
        fsum_q <= win_close ? '0 : sig_full;
        usum_q <= win_close ? '0 : tot_full;
      end
      if (win_close) zn_pend_q <= ~noise_pos;
      if (state_q == StDone) begin
        snr_q <= snr_new;
        zn_q  <= zn_pend_q;
      end
    end
  end

  // The result is presented during DONE and captured at its end so snr holds between pulses.
  assign snr        = (state_q == StDone) ? snr_new : snr_q;
  assign zero_noise = (state_q == StDone) ? zn_pend_q : zn_q;
  assign snr_valid  = (state_q == StDone);
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_snr_window_estimator.sv
// Scoreboard bench for snr_window_estimator; follows SNR_EMA_EN when defined.
module tb_snr_window_estimator;

  localparam int WIN     = 256;
  localparam int ALLONES = 131071;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0;
  logic [9:0] filtered = '0;
  logic [9:0] un_filtered = '0;
  logic [16:0] snr;
  logic       snr_valid;
  logic       zero_noise;
  logic       busy;

  snr_window_estimator dut (
    .clk         (clk),
    .rstn        (rstn),
    .en          (en),
    .filtered    (filtered),
    .un_filtered (un_filtered),
    .snr         (snr),
    .snr_valid   (snr_valid),
    .zero_noise  (zero_noise),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     snr;
    int     zn;
    longint cyc;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint mfs = 0;
  longint mus = 0;
  int     mcnt = 0;
  int     prev_snr = 0;
  bit     first = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: integer arithmetic on the whole window.
  function automatic void close_window();
    exp_t   e;
    longint noise;
    longint q;
    noise = mus - mfs;
    if (noise <= 0) begin
      q = ALLONES; e.zn = 1; e.cyc = cyc + 1;
    end else begin
      q = (mfs * 16) / noise;
      if (q > ALLONES) q = ALLONES;
      e.zn = 0; e.cyc = cyc + 23;
    end
`ifdef SNR_EMA_EN
    if (!first) q = prev_snr + ((int'(q) - prev_snr) >>> 2);
`endif
    first    = 1'b0;
    prev_snr = int'(q);
    e.snr    = int'(q);
    sb.push_back(e);
    mfs = 0; mus = 0; mcnt = 0;
  endfunction

  task automatic drive(input bit e, input int f, input int u);
    en = e; filtered = 10'(f); un_filtered = 10'(u);
    if (e) begin
      mfs += f; mus += u; mcnt++;
      if (mcnt == WIN) close_window();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    sb.delete();
    mfs = 0; mus = 0; mcnt = 0; first = 1'b1; prev_snr = 0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 600 && sb.size() != 0; i++) begin
      en = 1'b0; @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d results still pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (snr_valid) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: snr_valid=1 at cycle %0d with nothing pending", cyc);
      end else begin
        e = sb.pop_front();
        if (snr !== 17'(e.snr)) begin
          errors++;
          $display("FAIL snr_value: got %0d, expected %0d", snr, e.snr);
        end
        checks++;
        if (zero_noise !== e.zn[0]) begin
          errors++;
          $display("FAIL zero_noise: got %0b, expected %0b", zero_noise, e.zn[0]);
        end
        checks++;
        if (cyc !== e.cyc) begin
          errors++;
          $display("FAIL pulse_cycle: got %0d, expected %0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if ({snr, snr_valid, zero_noise, busy} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 0", {snr, snr_valid, zero_noise, busy});
    end
    rstn = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b0 || snr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%0b valid=%0b, expected 0 0", busy, snr_valid);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < WIN; i++) drive(1'b1, 100, 150);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %0b, expected 1", busy);
    end
    wait_drain("basic");
    checks++;
    if (snr !== 17'd32) begin
      errors++;
      $display("FAIL basic_hold: got %0d, expected 32", snr);
    end
  endtask

  task automatic test_zero_noise();
    for (int i = 0; i < WIN; i++) drive(1'b1, 500, 500);
    wait_drain("zero_noise");
    for (int i = 0; i < WIN; i++) drive(1'b1, 600, 500);
    wait_drain("negative_noise");
  endtask

  task automatic test_quotients();
    for (int i = 0; i < WIN; i++) drive(1'b1, 1022, 1023);
    wait_drain("q16352");
    for (int i = 0; i < WIN; i++) drive(1'b1, 0, 300);
    wait_drain("q0");
    // Noise of one forces a quotient far above the output range.
    for (int i = 0; i < WIN; i++) drive(1'b1, 1000, (i == 0) ? 1001 : 1000);
    wait_drain("saturate");
  endtask

  task automatic test_en_toggle();
    for (int i = 0; i < WIN - 1; i++) begin
      drive(1'b1, 100, 150);
      drive(1'b0, 999, 7);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL toggle_early: busy=%0b before last sample, expected 0", busy);
    end
    drive(1'b1, 100, 150);
    wait_drain("en_toggle");
  endtask

  task automatic test_back_to_back();
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < WIN; i++)
        drive(1'b1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
    wait_drain("back_to_back");
  endtask

  task automatic test_reset_mid_window();
    for (int i = 0; i < 100; i++) drive(1'b1, 700, 100);
    do_reset();
    checks++;
    if ({snr, snr_valid, zero_noise, busy} !== 20'd0) begin
      errors++;
      $display("FAIL rst_window_outputs: got %h, expected 0", {snr, snr_valid, zero_noise, busy});
    end
    for (int i = 0; i < WIN; i++) drive(1'b1, 100, 150);
    wait_drain("after_rst_window");
  endtask

  task automatic test_reset_mid_div();
    for (int i = 0; i < WIN; i++) drive(1'b1, 100, 150);
    repeat (5) drive(1'b0, 0, 0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_div_busy: got %0b, expected 1", busy);
    end
    do_reset();
    repeat (30) drive(1'b0, 0, 0);
    checks++;
    if ({snr, zero_noise, busy} !== 19'd0) begin
      errors++;
      $display("FAIL rst_div_outputs: got %h, expected 0", {snr, zero_noise, busy});
    end
    for (int i = 0; i < WIN; i++) drive(1'b1, 1022, 1023);
    wait_drain("after_rst_div");
  endtask

  task automatic test_ema();
    do_reset();
    for (int i = 0; i < WIN; i++) drive(1'b1, 100, 150);
    wait_drain("ema_first");
    for (int i = 0; i < WIN; i++) drive(1'b1, 100, 125);
    wait_drain("ema_second");
    checks++;
`ifdef SNR_EMA_EN
    if (snr !== 17'd40) begin
      errors++;
      $display("FAIL ema_result: got %0d, expected 40", snr);
    end
`else
    if (snr !== 17'd64) begin
      errors++;
      $display("FAIL raw_result: got %0d, expected 64", snr);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_noise();
    test_quotients();
    test_en_toggle();
    test_back_to_back();
    test_reset_mid_window();
    test_reset_mid_div();
    test_ema();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
